// File: rtl/alu_pkg.sv
// Shared constants for the ALU stage: opcodes, FSM states, flag bit positions.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADC  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SBB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_ROL  = 4'hA;
    localparam logic [3:0] OP_ROR  = 4'hB;
    localparam logic [3:0] OP_INC  = 4'hC;
    localparam logic [3:0] OP_DEC  = 4'hD;
    localparam logic [3:0] OP_MUL  = 4'hE;
    localparam logic [3:0] OP_PASS = 4'hF;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    // Bit positions inside the 4-bit flag register
    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 2;
    localparam int FLG_V = 3;

endpackage

// File: rtl/mul_shift_add.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per step, LSB first.
// acc holds {partial high, remaining multiplier bits}; the adder is one bit wider
// so the carry out of each add is shifted into the product rather than lost.
module mul_shift_add #(
    parameter int WIDTH      = 8,
    parameter int MUL_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod_nxt
);

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     sum;

    // One shift-add step: conditionally add the multiplicand, then shift right
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        prod_nxt = {sum, acc[WIDTH-1:1]};
    end

    // done flags the step that completes the final iteration
    assign done = step && (cnt == CW'(MUL_CYCLES - 1));

    // Operand latch on load, accumulate/shift on every step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (load) begin
            mcand <= a;
            acc   <= {{WIDTH{1'b0}}, b};
            cnt   <= '0;
        end else if (step) begin
            acc   <= prod_nxt;
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alu_unit.sv
// 8-bit ALU stage behind the general register: single-cycle ALU ops plus an
// 8-cycle iterative multiply, with registered result and C/Z/N/V flags.
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MUL_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [3:0]       Op_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    output logic [WIDTH-1:0] Result_o,
    output logic [WIDTH-1:0] ResultHi_o,
    output logic             C_o,
    output logic             Z_o,
    output logic             N_o,
    output logic             V_o,
    output logic             busy_o,
    output logic             done_o
);

    logic [0:0]         state;
    logic [3:0]         flags_q;
    logic [3:0]         flags_nxt;
    logic [3:0]         mul_flags;
    logic [WIDTH:0]     t9;
    logic [WIDTH-1:0]   res;
    logic               accept;
    logic               mul_load;
    logic               mul_done;
    logic [2*WIDTH-1:0] prod;

    assign busy_o   = (state == ST_MUL);
    assign accept   = start_i && !busy_o;
    assign mul_load = accept && (Op_i == OP_MUL);

    assign C_o = flags_q[FLG_C];
    assign Z_o = flags_q[FLG_Z];
    assign N_o = flags_q[FLG_N];
    assign V_o = flags_q[FLG_V];

    mul_shift_add #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) u_mul (
        .clk      (clk),
        .rst      (rst),
        .load     (mul_load),
        .step     (busy_o),
        .a        (A_i),
        .b        (B_i),
        .done     (mul_done),
        .prod_nxt (prod)
    );

    // Single-cycle datapath; carry/borrow come from the 9th bit of t9
    always_comb begin
        t9        = '0;
        res       = B_i;
        flags_nxt = '0;
        flags_nxt[FLG_C] = flags_q[FLG_C];
        case (Op_i)
            OP_ADD, OP_ADC: begin
                t9  = {1'b0, A_i} + {1'b0, B_i} + {{WIDTH{1'b0}}, (Op_i == OP_ADC) & flags_q[FLG_C]};
                res = t9[WIDTH-1:0];
                flags_nxt[FLG_C] = t9[WIDTH];
                flags_nxt[FLG_V] = (A_i[WIDTH-1] == B_i[WIDTH-1]) && (res[WIDTH-1] != A_i[WIDTH-1]);
            end
            OP_SUB, OP_SBB: begin
                t9  = {1'b0, A_i} - {1'b0, B_i} - {{WIDTH{1'b0}}, (Op_i == OP_SBB) & flags_q[FLG_C]};
                res = t9[WIDTH-1:0];
                flags_nxt[FLG_C] = t9[WIDTH];
                flags_nxt[FLG_V] = (A_i[WIDTH-1] != B_i[WIDTH-1]) && (res[WIDTH-1] != A_i[WIDTH-1]);
            end
            OP_AND: res = A_i & B_i;
            OP_OR:  res = A_i | B_i;
            OP_XOR: res = A_i ^ B_i;
            OP_NOT: res = ~A_i;
            OP_SHL: begin
                res = {A_i[WIDTH-2:0], 1'b0};
                flags_nxt[FLG_C] = A_i[WIDTH-1];
            end
            OP_SHR: begin
                res = {1'b0, A_i[WIDTH-1:1]};
                flags_nxt[FLG_C] = A_i[0];
            end
            OP_ROL: begin
                res = {A_i[WIDTH-2:0], flags_q[FLG_C]};
                flags_nxt[FLG_C] = A_i[WIDTH-1];
            end
            OP_ROR: begin
                res = {flags_q[FLG_C], A_i[WIDTH-1:1]};
                flags_nxt[FLG_C] = A_i[0];
            end
            OP_INC: begin
                res = A_i + WIDTH'(1);
                flags_nxt[FLG_V] = (A_i == {1'b0, {(WIDTH-1){1'b1}}});
            end
            OP_DEC: begin
                res = A_i - WIDTH'(1);
                flags_nxt[FLG_V] = (A_i == {1'b1, {(WIDTH-1){1'b0}}});
            end
            default: res = B_i;
        endcase
        flags_nxt[FLG_Z] = (res == '0);
        flags_nxt[FLG_N] = res[WIDTH-1];
    end

    // Multiply flags are taken from the full 16-bit product
    always_comb begin
        mul_flags        = '0;
        mul_flags[FLG_C] = (prod[2*WIDTH-1:WIDTH] != '0);
        mul_flags[FLG_Z] = (prod == '0);
        mul_flags[FLG_N] = prod[2*WIDTH-1];
    end

    // FSM plus result/flag registers; done_o is a one-cycle pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            Result_o   <= '0;
            ResultHi_o <= '0;
            flags_q    <= '0;
            done_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (state == ST_IDLE) begin
                if (accept) begin
                    if (Op_i == OP_MUL) begin
                        state <= ST_MUL;
                    end else begin
                        Result_o   <= res;
                        ResultHi_o <= '0;
                        flags_q    <= flags_nxt;
                        done_o     <= 1'b1;
                    end
                end
            end else if (mul_done) begin
                Result_o   <= prod[WIDTH-1:0];
                ResultHi_o <= prod[2*WIDTH-1:WIDTH];
                flags_q    <= mul_flags;
                done_o     <= 1'b1;
                state      <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vector table, hand-written
// multiply/reset sequences, and randomized ops against an arithmetic model.
module tb_alu_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic [3:0] Op_i = 4'h0;
    logic [7:0] A_i = 8'h00;
    logic [7:0] B_i = 8'h00;
    logic [7:0] Result_o, ResultHi_o;
    logic       C_o, Z_o, N_o, V_o, busy_o, done_o;

    int total = 0;
    int bad   = 0;

    alu_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .Op_i       (Op_i),
        .A_i        (A_i),
        .B_i        (B_i),
        .Result_o   (Result_o),
        .ResultHi_o (ResultHi_o),
        .C_o        (C_o),
        .Z_o        (Z_o),
        .N_o        (N_o),
        .V_o        (V_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic [7:0] hi;
        logic       c, z, n, v;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] r, input logic c, input logic z,
                                input logic n, input logic v);
        vec_t t;
        t.op = op; t.a = a; t.b = b; t.r = r; t.hi = 8'h00;
        t.c = c; t.z = z; t.n = n; t.v = v;
        return t;
    endfunction

    // Reference model: plain integer arithmetic on the opcode definitions
    function automatic vec_t model(input logic [3:0] op, input logic [7:0] a,
                                   input logic [7:0] b, input logic cin);
        vec_t e;
        int ua, ub, ci, sa, sb, full, sres, p;
        ua = int'(a); ub = int'(b); ci = cin ? 1 : 0;
        sa = int'($signed(a)); sb = int'($signed(b));
        full = 0; sres = 0;
        e.op = op; e.a = a; e.b = b; e.hi = 8'h00; e.c = cin; e.v = 1'b0;
        case (op)
            4'h0: begin full = ua + ub;      sres = sa + sb;      e.c = (full > 255); e.v = (sres > 127 || sres < -128); end
            4'h1: begin full = ua + ub + ci; sres = sa + sb + ci; e.c = (full > 255); e.v = (sres > 127 || sres < -128); end
            4'h2: begin full = ua - ub;      sres = sa - sb;      e.c = (ua < ub);      e.v = (sres > 127 || sres < -128); end
            4'h3: begin full = ua - ub - ci; sres = sa - sb - ci; e.c = (ua < ub + ci); e.v = (sres > 127 || sres < -128); end
            4'h4: full = ua & ub;
            4'h5: full = ua | ub;
            4'h6: full = ua ^ ub;
            4'h7: full = 255 - ua;
            4'h8: begin full = ua * 2;            e.c = (ua >= 128); end
            4'h9: begin full = ua / 2;            e.c = (ua % 2 == 1); end
            4'hA: begin full = ua * 2 + ci;       e.c = (ua >= 128); end
            4'hB: begin full = ua / 2 + ci * 128; e.c = (ua % 2 == 1); end
            4'hC: begin full = ua + 1; e.v = (ua == 127); end
            4'hD: begin full = ua - 1; e.v = (ua == 128); end
            4'hE: full = 0;
            default: full = ub;
        endcase
        if (op == 4'hE) begin
            p    = ua * ub;
            e.r  = p[7:0];
            e.hi = p[15:8];
            e.c  = (p >= 256);
            e.z  = (p == 0);
            e.n  = (p >= 32768);
        end else begin
            e.r = full[7:0];
            e.z = (e.r == 8'h00);
            e.n = e.r[7];
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Compare the full output set against an expected record after a done pulse
    task automatic chk_out(input string nm, input vec_t e);
        chk({nm, ".done"}, 16'(done_o), 16'd1);
        chk({nm, ".busy"}, 16'(busy_o), 16'd0);
        chk({nm, ".r"},    16'(Result_o), 16'(e.r));
        chk({nm, ".hi"},   16'(ResultHi_o), 16'(e.hi));
        chk({nm, ".c"},    16'(C_o), 16'(e.c));
        chk({nm, ".z"},    16'(Z_o), 16'(e.z));
        chk({nm, ".n"},    16'(N_o), 16'(e.n));
        chk({nm, ".v"},    16'(V_o), 16'(e.v));
    endtask

    // Issue a MUL at the current negedge, optionally holding start high while busy
    task automatic run_mul(input string nm, input logic [7:0] a, input logic [7:0] b,
                           input bit hold, input vec_t e);
        Op_i = 4'hE; A_i = a; B_i = b; start_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk({nm, ".busy"}, 16'(busy_o), 16'd1);
            chk({nm, ".nodone"}, 16'(done_o), 16'd0);
            start_i = hold;
            Op_i = 4'h0; A_i = 8'h11; B_i = 8'h22;
        end
        @(negedge clk);
        chk_out(nm, e);
        start_i = 1'b0;
        @(negedge clk);
        chk({nm, ".pulse"}, 16'(done_o), 16'd0);
    endtask

    vec_t tbl[17];
    vec_t e;
    logic c_m;
    logic [3:0] op;
    logic [7:0] a, b;
    int done_seen;

    initial begin
        tbl[0]  = mk(4'h0, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 0);
        tbl[1]  = mk(4'h0, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 1);
        tbl[2]  = mk(4'h3, 8'h10, 8'h20, 8'hF0, 1, 0, 1, 0);
        tbl[3]  = mk(4'h8, 8'h81, 8'h00, 8'h02, 1, 0, 0, 0);
        tbl[4]  = mk(4'hB, 8'h02, 8'h00, 8'h81, 0, 0, 1, 0);
        tbl[5]  = mk(4'h4, 8'hF0, 8'h0F, 8'h00, 0, 1, 0, 0);
        tbl[6]  = mk(4'h9, 8'h01, 8'h00, 8'h00, 1, 1, 0, 0);
        tbl[7]  = mk(4'h1, 8'h01, 8'h01, 8'h03, 0, 0, 0, 0);
        tbl[8]  = mk(4'hD, 8'h80, 8'h00, 8'h7F, 0, 0, 0, 1);
        tbl[9]  = mk(4'h2, 8'h00, 8'h01, 8'hFF, 1, 0, 1, 0);
        tbl[10] = mk(4'hA, 8'h40, 8'h00, 8'h81, 0, 0, 1, 0);
        tbl[11] = mk(4'hC, 8'h7F, 8'h00, 8'h80, 0, 0, 1, 1);
        tbl[12] = mk(4'h6, 8'hAA, 8'h55, 8'hFF, 0, 0, 1, 0);
        tbl[13] = mk(4'h7, 8'h0F, 8'h00, 8'hF0, 0, 0, 1, 0);
        tbl[14] = mk(4'hF, 8'h99, 8'h00, 8'h00, 0, 1, 0, 0);
        tbl[15] = mk(4'h2, 8'h80, 8'h01, 8'h7F, 0, 0, 0, 1);
        tbl[16] = mk(4'h5, 8'h80, 8'h01, 8'h81, 0, 0, 1, 0);

        // Reset state
        #12;
        chk("rst.r",    16'(Result_o), 16'd0);
        chk("rst.hi",   16'(ResultHi_o), 16'd0);
        chk("rst.flag", 16'({C_o, Z_o, N_o, V_o}), 16'd0);
        chk("rst.busy", 16'(busy_o), 16'd0);
        chk("rst.done", 16'(done_o), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed table, issued back-to-back (one accept per cycle)
        for (int i = 0; i < 17; i++) begin
            Op_i = tbl[i].op; A_i = tbl[i].a; B_i = tbl[i].b; start_i = 1'b1;
            @(negedge clk);
            chk_out($sformatf("tbl%0d", i), tbl[i]);
        end
        start_i = 1'b0;
        @(negedge clk);
        chk("tbl.pulse", 16'(done_o), 16'd0);

        // MUL FF*FF with start held during busy
        e = mk(4'hE, 8'hFF, 8'hFF, 8'h01, 1, 0, 1, 0); e.hi = 8'hFE;
        run_mul("mulFF", 8'hFF, 8'hFF, 1'b1, e);

        // MUL 00*37 then INC 7F
        e = mk(4'hE, 8'h00, 8'h37, 8'h00, 0, 1, 0, 0);
        run_mul("mul00", 8'h00, 8'h37, 1'b0, e);
        Op_i = 4'hC; A_i = 8'h7F; start_i = 1'b1;
        @(negedge clk);
        chk_out("inc7f", mk(4'hC, 8'h7F, 8'h00, 8'h80, 0, 0, 1, 1));
        start_i = 1'b0;

        // Reset three cycles into a multiply
        @(negedge clk);
        Op_i = 4'hE; A_i = 8'hAB; B_i = 8'hCD; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mrst.busy_before", 16'(busy_o), 16'd1);
        rst = 1'b1;
        #1;
        chk("mrst.r",    16'(Result_o), 16'd0);
        chk("mrst.hi",   16'(ResultHi_o), 16'd0);
        chk("mrst.flag", 16'({C_o, Z_o, N_o, V_o}), 16'd0);
        chk("mrst.busy", 16'(busy_o), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done_o || busy_o) done_seen++;
        end
        chk("mrst.quiet", 16'(done_seen), 16'd0);
        Op_i = 4'h0; A_i = 8'h01; B_i = 8'h02; start_i = 1'b1;
        @(negedge clk);
        chk_out("mrst.add", mk(4'h0, 8'h01, 8'h02, 8'h03, 0, 0, 0, 0));

        // Randomized ops against the model
        c_m = 1'b0;
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
            e = model(op, a, b, c_m);
            Op_i = op; A_i = a; B_i = b; start_i = 1'b1;
            if (op == 4'hE) begin
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    chk("rnd.busy", 16'(busy_o), 16'd1);
                    chk("rnd.nodone", 16'(done_o), 16'd0);
                    start_i = 1'($urandom);
                    Op_i = 4'($urandom); A_i = 8'($urandom); B_i = 8'($urandom);
                end
            end
            @(negedge clk);
            chk_out($sformatf("rnd%0d_op%h_%h_%h", i, op, a, b), e);
            c_m = e.c;
            if ($urandom_range(0, 3) == 0) begin
                start_i = 1'b0;
                @(negedge clk);
                chk("rnd.idle", 16'(done_o), 16'd0);
            end
        end
        start_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- 8-bit ALU stage directly downstream of the general register.
- Operand A comes from the register output. Result_o feeds back into one of the register's 8 source inputs.
- Single-cycle arithmetic, logic and shift ops; 8-cycle iterative unsigned multiply.
- Registered result and registered C/Z/N/V status flags; start/busy/done handshake toward the control sequencer.

Parameters:
- WIDTH, 8, operand/result width (only 8 is supported; exposed for the multiplier counter width).
- MUL_CYCLES, 8, multiply iteration count; must equal WIDTH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  request an operation; sampled only when busy_o=0
- Op_i  in  4  opcode; sampled with start_i
- A_i  in  8  operand A, from general register output
- B_i  in  8  operand B
- Result_o  out  8  result low byte
- ResultHi_o  out  8  multiply high byte; 0 after any non-MUL op
- C_o  out  1  carry/borrow flag
- Z_o  out  1  zero flag
- N_o  out  1  negative flag (result MSB)
- V_o  out  1  signed overflow flag
- busy_o  out  1  multiply in progress
- done_o  out  1  one-cycle pulse: result/flags valid and updated

Behaviour:
- Reset (async, rst=1): Result_o=0, ResultHi_o=0, C/Z/N/V=0, busy_o=0, done_o=0, FSM=IDLE. Reset mid-multiply aborts with no partial result.
- Accept: a rising edge with start_i=1 and busy_o=0. start_i while busy_o=1 is ignored (no queueing). Op_i, A_i and B_i are sampled only at accept.
- Opcodes:
  - 0 ADD: A+B.
  - 1 ADC: A+B+C.
  - 2 SUB: A-B.
  - 3 SBB: A-B-C.
  - 4 AND.
  - 5 OR.
  - 6 XOR.
  - 7 NOT: ~A.
  - 8 SHL: A<<1, C=A[7].
  - 9 SHR: logical, A>>1, C=A[0].
  - A ROL: {A[6:0],C}, C=A[7].
  - B ROR: {C,A[7:1]}, C=A[0].
  - C INC: A+1.
  - D DEC: A-1.
  - E MUL: unsigned A*B, 16-bit.
  - F PASS: B.
- Single-cycle ops: result and flags are registered at the accept edge; done_o=1 for the following cycle. Latency 1, back-to-back accepts allowed every cycle.
- Flag rules:
  - ADD/ADC: C=carry out; V=(A7==B7)&&(R7!=A7).
  - SUB/SBB: C=borrow (1 when unsigned A < B(+C)); V=(A7!=B7)&&(R7!=A7).
  - Logic ops and PASS: C preserved, V=0.
  - Shifts/rotates: C as listed above, V=0.
  - INC: V=(A==8'h7F). DEC: V=(A==8'h80). C preserved for both.
  - MUL: Z=(16-bit product==0), N=product[15], C=(high byte!=0), V=0.
  - Every op except MUL: Z=(R==0), N=R[7].
- Multiply FSM, states IDLE, MUL:
  - Accept with Op=E: operands latched into the multiplier, busy_o=1, iteration counter=0, FSM→MUL.
  - Each MUL cycle performs one shift-add step (one multiplier bit per cycle, LSB first).
  - On the edge completing iteration MUL_CYCLES-1: Result_o/ResultHi_o/flags are updated, busy_o=0, done_o pulses, FSM→IDLE.
  - Accept at edge T → done_o high in the cycle after edge T+8. busy_o is high for exactly 8 cycles.
  - A new start_i is accepted on the same edge that ends busy only if busy_o was already 0 when sampled; it therefore cannot be accepted on that edge.
- Outputs hold between operations. done_o=0 except for the pulse.
- Width rules: all arithmetic uses a 9-bit intermediate for carry/borrow. The multiplier accumulator is 16 bits plus a carry bit.

Decomposition:
- Shared package alu_pkg: 4-bit opcode constants (OP_ADD … OP_PASS), FSM state encoding (ST_IDLE, ST_MUL), flag bit indices.
- One sub-module mul_shift_add: iterative 8x8 unsigned multiplier with load/step/done and 16-bit product. The top level holds the FSM, the combinational single-cycle datapath and the flag registers.

Test Plan:
- Reset then ADD A=8'hFF, B=8'h01 → Result_o=8'h00, C=1, Z=1, N=0, V=0, done_o one cycle after accept.
- ADD A=8'h7F, B=8'h01 → Result_o=8'h80, V=1, N=1, C=0. Then SBB A=8'h10, B=8'h20 with C=0 → Result_o=8'hF0, C=1, N=1.
- Set C=1 via SHL A=8'h81 (Result_o=8'h02), then ROR A=8'h02 → Result_o=8'h81, C=0. Then AND A=8'hF0, B=8'h0F → Result_o=0, Z=1, C unchanged.
- MUL A=8'hFF, B=8'hFF → busy_o high 8 cycles. start_i held high during busy is ignored. After completion: Result_o=8'h01, ResultHi_o=8'hFE, C=1, Z=0, N=1, single done_o pulse.
- MUL A=8'h00, B=8'h37 → product 0, Z=1, C=0. A following INC A=8'h7F accepted after done → Result_o=8'h80, V=1, ResultHi_o=0.
- Assert rst 3 cycles into a MUL → all outputs 0 immediately (asynchronous); after release, busy_o=0, no done_o pulse, and the next ADD completes normally.
